// File: rtl/ahb_pkg.sv
// Shared AHB definitions: transfer/response/burst encodings, error-FSM
// state encoding and the owner-index width helper.

`ifndef NUM_MASTERS
`define NUM_MASTERS 4
`endif

package ahb_pkg;

    // Transfer type carried on Htrans.
    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    // Slave response carried on Hresp.
    typedef enum logic {
        HRESP_OKAY  = 1'b0,
        HRESP_ERROR = 1'b1
    } hresp_e;

    // Burst type carried on Hburst.
    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'b000,
        HBURST_INCR   = 3'b001,
        HBURST_WRAP4  = 3'b010,
        HBURST_INCR4  = 3'b011,
        HBURST_WRAP8  = 3'b100,
        HBURST_INCR8  = 3'b101,
        HBURST_WRAP16 = 3'b110,
        HBURST_INCR16 = 3'b111
    } hburst_e;

    // Two-cycle ERROR cancellation states.
    typedef enum logic [1:0] {
        ERR_OKAY = 2'b00,
        ERR_ERR1 = 2'b01,
        ERR_ERR2 = 2'b10
    } err_state_e;

    // Width of an owner index for n masters; a single master still needs one bit.
    function automatic int master_width(input int n);
        int w;
        if (n > 1) begin
            w = $clog2(n);
        end else begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/ahb_err_fsm.sv
// Error-cancel FSM. A two-cycle AHB ERROR starts with S_Hresp=1 while
// S_Hready=0; from the following cycle until one cycle after S_Hready rises,
// kill is asserted so that the transfer pipelined behind the failing one and
// the next address phase are both turned into IDLE. A further ERROR seen
// while already cancelling does not restart the sequence.

module ahb_err_fsm
    import ahb_pkg::*;
(
    input  logic Hclk,
    input  logic Hresetn,
    input  logic S_Hready,
    input  logic S_Hresp,
    output logic kill
);

    err_state_e state;

    // State register with kill registered alongside it (kill mirrors "state is not OKAY").
    always_ff @(posedge Hclk) begin
        if (!Hresetn) begin
            state <= ERR_OKAY;
            kill  <= 1'b0;
        end else begin
            case (state)
                ERR_OKAY: begin
                    if (S_Hresp && !S_Hready) begin
                        state <= ERR_ERR1;
                        kill  <= 1'b1;
                    end else begin
                        state <= ERR_OKAY;
                        kill  <= 1'b0;
                    end
                end
                ERR_ERR1: begin
                    if (S_Hready) begin
                        state <= ERR_ERR2;
                        kill  <= 1'b1;
                    end else begin
                        state <= ERR_ERR1;
                        kill  <= 1'b1;
                    end
                end
                ERR_ERR2: begin
                    state <= ERR_OKAY;
                    kill  <= 1'b0;
                end
                default: begin
                    state <= ERR_OKAY;
                    kill  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/ahb_master_mux.sv
// Master-side AHB bus multiplexer. The address phase follows the arbiter's
// Hmaster combinationally; the data phase follows data_owner, which trails
// Hmaster by one S_Hready-qualified cycle. Transfers are forced to IDLE while
// an ERROR is being cancelled, or when a new owner tries to start with SEQ
// (it has no burst of its own to continue), which also raises Hproto_err.

module ahb_master_mux
    import ahb_pkg::*;
#(
    parameter int NUM_MASTERS  = `NUM_MASTERS,
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int MASTER_WIDTH = master_width(NUM_MASTERS)
) (
    input  logic                    Hclk,
    input  logic                    Hresetn,
    input  logic [MASTER_WIDTH-1:0] Hmaster,
    input  logic [ADDR_WIDTH-1:0]   M_Haddr  [NUM_MASTERS],
    input  logic [1:0]              M_Htrans [NUM_MASTERS],
    input  logic [NUM_MASTERS-1:0]  M_Hwrite,
    input  logic [2:0]              M_Hsize  [NUM_MASTERS],
    input  logic [2:0]              M_Hburst [NUM_MASTERS],
    input  logic [DATA_WIDTH-1:0]   M_Hwdata [NUM_MASTERS],
    output logic [ADDR_WIDTH-1:0]   Haddr,
    output logic [1:0]              Htrans,
    output logic                    Hwrite,
    output logic [2:0]              Hsize,
    output logic [2:0]              Hburst,
    output logic [DATA_WIDTH-1:0]   Hwdata,
    input  logic [DATA_WIDTH-1:0]   S_Hrdata,
    input  logic                    S_Hready,
    input  logic                    S_Hresp,
    output logic [DATA_WIDTH-1:0]   M_Hrdata,
    output logic [NUM_MASTERS-1:0]  M_Hready,
    output logic [NUM_MASTERS-1:0]  M_Hresp,
    output logic [MASTER_WIDTH-1:0] Hmaster_data,
    output logic                    Hproto_err
);

    logic [MASTER_WIDTH-1:0] sel;
    logic [MASTER_WIDTH-1:0] data_owner;
    logic [MASTER_WIDTH-1:0] prev_owner;
    logic [1:0]              raw_trans;
    logic                    guard;
    logic                    kill;

    ahb_err_fsm u_err_fsm (
        .Hclk     (Hclk),
        .Hresetn  (Hresetn),
        .S_Hready (S_Hready),
        .S_Hresp  (S_Hresp),
        .kill     (kill)
    );

    // Clamp the arbiter's index: out-of-range values fall back to master 0.
    always_comb begin
        sel = '0;
        if (32'(Hmaster) < 32'(NUM_MASTERS)) begin
            sel = Hmaster;
        end else begin
            sel = '0;
        end
    end

    // Address/control path and the handover guard.
    always_comb begin
        Haddr     = M_Haddr[sel];
        Hwrite    = M_Hwrite[sel];
        Hsize     = M_Hsize[sel];
        Hburst    = M_Hburst[sel];
        raw_trans = M_Htrans[sel];
        guard     = (sel != prev_owner) && (raw_trans == HTRANS_SEQ);
        if (kill || guard) begin
            Htrans = HTRANS_IDLE;
        end else begin
            Htrans = raw_trans;
        end
        Hproto_err = guard;
    end

    // Data path and response fan-out; only the data-phase owner sees Hresp.
    always_comb begin
        Hwdata       = M_Hwdata[data_owner];
        Hmaster_data = data_owner;
        M_Hrdata     = S_Hrdata;
        M_Hready     = {NUM_MASTERS{S_Hready}};
        M_Hresp      = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (MASTER_WIDTH'(i) == data_owner) begin
                M_Hresp[i] = S_Hresp;
            end else begin
                M_Hresp[i] = 1'b0;
            end
        end
    end

    // Owner pipeline: both owners advance only on S_Hready, holding through wait states.
    always_ff @(posedge Hclk) begin
        if (!Hresetn) begin
            data_owner <= '0;
            prev_owner <= '0;
        end else if (S_Hready) begin
            data_owner <= sel;
            prev_owner <= sel;
        end else begin
            data_owner <= data_owner;
            prev_owner <= prev_owner;
        end
    end

endmodule

// File: tb/tb_ahb_master_mux.sv
// Scoreboard bench for ahb_master_mux: the driver applies stimulus just after
// each rising edge and pushes the expected bus picture into a queue; a monitor
// on the falling edge pops and compares.
`timescale 1ns/1ps

module tb_ahb_master_mux;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = 2;

    logic          Hclk = 1'b0;
    logic          Hresetn;
    logic [MW-1:0] Hmaster;
    logic [AW-1:0] M_Haddr  [N];
    logic [1:0]    M_Htrans [N];
    logic [N-1:0]  M_Hwrite;
    logic [2:0]    M_Hsize  [N];
    logic [2:0]    M_Hburst [N];
    logic [DW-1:0] M_Hwdata [N];
    logic [AW-1:0] Haddr;
    logic [1:0]    Htrans;
    logic          Hwrite;
    logic [2:0]    Hsize;
    logic [2:0]    Hburst;
    logic [DW-1:0] Hwdata;
    logic [DW-1:0] S_Hrdata;
    logic          S_Hready;
    logic          S_Hresp;
    logic [DW-1:0] M_Hrdata;
    logic [N-1:0]  M_Hready;
    logic [N-1:0]  M_Hresp;
    logic [MW-1:0] Hmaster_data;
    logic          Hproto_err;

    ahb_master_mux #(
        .NUM_MASTERS (N),
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .MASTER_WIDTH(MW)
    ) dut (
        .Hclk(Hclk), .Hresetn(Hresetn), .Hmaster(Hmaster),
        .M_Haddr(M_Haddr), .M_Htrans(M_Htrans), .M_Hwrite(M_Hwrite),
        .M_Hsize(M_Hsize), .M_Hburst(M_Hburst), .M_Hwdata(M_Hwdata),
        .Haddr(Haddr), .Htrans(Htrans), .Hwrite(Hwrite), .Hsize(Hsize),
        .Hburst(Hburst), .Hwdata(Hwdata), .S_Hrdata(S_Hrdata),
        .S_Hready(S_Hready), .S_Hresp(S_Hresp), .M_Hrdata(M_Hrdata),
        .M_Hready(M_Hready), .M_Hresp(M_Hresp), .Hmaster_data(Hmaster_data),
        .Hproto_err(Hproto_err)
    );

    always #5 Hclk = ~Hclk;

    typedef struct {
        string         tag;
        logic [1:0]    trans;
        logic          perr;
        logic [AW-1:0] addr;
        logic          wr;
        logic [2:0]    size;
        logic [2:0]    burst;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        logic [MW-1:0] mdata;
        logic [N-1:0]  rdy;
        logic [N-1:0]  resp;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    // Reference model: who owns the data phase, who last owned the address
    // phase, and how many cancelled cycles remain after an ERROR.
    int m_data_owner = 0;
    int m_last_owner = 0;
    bit m_wait_ready = 1'b0;   // ERROR seen, waiting for its second (ready) cycle
    bit m_one_more   = 1'b0;   // ready seen, one more address phase to cancel

    task automatic chk(input string nm, input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s [%s] cycle %0d: got %0h expected %0h", nm, tag, cyc, act, exp);
        end
    endtask

    // Advance the model across the rising edge using the inputs present at it.
    task automatic tick();
        int s;
        @(posedge Hclk);
        cyc++;
        s = (int'(Hmaster) < N) ? int'(Hmaster) : 0;
        if (!Hresetn) begin
            m_data_owner = 0;
            m_last_owner = 0;
            m_wait_ready = 1'b0;
            m_one_more   = 1'b0;
        end else begin
            if (S_Hready) begin
                m_data_owner = s;
                m_last_owner = s;
            end
            if (m_one_more) begin
                m_one_more = 1'b0;
            end else if (m_wait_ready) begin
                if (S_Hready) begin
                    m_wait_ready = 1'b0;
                    m_one_more   = 1'b1;
                end
            end else if (S_Hresp && !S_Hready) begin
                m_wait_ready = 1'b1;
            end
        end
        #1;
    endtask

    // Compute what the bus must show for the inputs now applied.
    task automatic push(input string tag);
        exp_t e;
        int   s;
        bit   handover_seq;
        s = (int'(Hmaster) < N) ? int'(Hmaster) : 0;
        handover_seq = (s != m_last_owner) && (M_Htrans[s] == 2'b11);
        e.tag   = tag;
        e.trans = (m_wait_ready || m_one_more || handover_seq) ? 2'b00 : M_Htrans[s];
        e.perr  = handover_seq;
        e.addr  = M_Haddr[s];
        e.wr    = M_Hwrite[s];
        e.size  = M_Hsize[s];
        e.burst = M_Hburst[s];
        e.wdata = M_Hwdata[m_data_owner];
        e.rdata = S_Hrdata;
        e.mdata = MW'(m_data_owner);
        e.rdy   = S_Hready ? {N{1'b1}} : {N{1'b0}};
        e.resp  = S_Hresp ? (N'(1) << m_data_owner) : {N{1'b0}};
        sbq.push_back(e);
    endtask

    // Monitor: compare the DUT against the oldest pending expectation.
    always @(negedge Hclk) begin
        exp_t e;
        if (sbq.size() != 0) begin
            e = sbq.pop_front();
            chk("Htrans",       e.tag, 64'(Htrans),       64'(e.trans));
            chk("Hproto_err",   e.tag, 64'(Hproto_err),   64'(e.perr));
            chk("Haddr",        e.tag, 64'(Haddr),        64'(e.addr));
            chk("Hwrite",       e.tag, 64'(Hwrite),       64'(e.wr));
            chk("Hsize",        e.tag, 64'(Hsize),        64'(e.size));
            chk("Hburst",       e.tag, 64'(Hburst),       64'(e.burst));
            chk("Hwdata",       e.tag, 64'(Hwdata),       64'(e.wdata));
            chk("M_Hrdata",     e.tag, 64'(M_Hrdata),     64'(e.rdata));
            chk("Hmaster_data", e.tag, 64'(Hmaster_data), 64'(e.mdata));
            chk("M_Hready",     e.tag, 64'(M_Hready),     64'(e.rdy));
            chk("M_Hresp",      e.tag, 64'(M_Hresp),      64'(e.resp));
        end
    end

    task automatic randomize_masters();
        for (int i = 0; i < N; i++) begin
            M_Haddr[i]  = $urandom;
            M_Htrans[i] = 2'($urandom_range(0, 3));
            M_Hwrite[i] = 1'($urandom_range(0, 1));
            M_Hsize[i]  = 3'($urandom_range(0, 7));
            M_Hburst[i] = 3'($urandom_range(0, 7));
            M_Hwdata[i] = $urandom;
        end
    endtask

    initial begin
        Hresetn  = 1'b0;
        Hmaster  = 2'd0;
        S_Hrdata = 32'h0;
        S_Hready = 1'b1;
        S_Hresp  = 1'b0;
        randomize_masters();
        M_Htrans[0] = 2'b10;

        // Reset held for three cycles with master 0 presenting NONSEQ.
        for (int i = 0; i < 3; i++) begin
            tick();
            push("reset");
        end
        tick();
        Hresetn = 1'b1;
        push("after_reset");

        // Pipelined ownership 0 -> 1.
        tick();
        Hmaster     = 2'd1;
        M_Htrans[1] = 2'b10;
        M_Haddr[1]  = 32'h0000_0100;
        S_Hready    = 1'b1;
        push("handover_nonseq");
        tick();
        M_Htrans[1] = 2'b11;
        push("owner1_data");

        // Wait states while Hmaster moves back to 0.
        tick();
        Hmaster     = 2'd0;
        M_Htrans[0] = 2'b10;
        S_Hready    = 1'b0;
        push("wait1");
        tick();
        push("wait2");
        tick();
        S_Hready = 1'b1;
        push("wait_release");
        tick();
        M_Htrans[0] = 2'b11;
        push("owner0_data");

        // Two-cycle ERROR while master 0 keeps asking for SEQ.
        tick();
        S_Hresp  = 1'b1;
        S_Hready = 1'b0;
        S_Hrdata = 32'hDEAD_BEEF;
        push("err_cycle1");
        tick();
        S_Hready = 1'b1;
        push("err_cycle2");
        tick();
        S_Hresp = 1'b0;
        push("err_tail");
        tick();
        push("err_done");

        // Illegal handover: new owner starts with SEQ.
        tick();
        Hmaster     = 2'd1;
        M_Htrans[1] = 2'b11;
        push("bad_handover");
        tick();
        M_Htrans[1] = 2'b10;
        push("after_bad_handover");

        // Response isolation at data owner 2.
        tick();
        Hmaster     = 2'd2;
        M_Htrans[2] = 2'b10;
        push("to_owner2");
        tick();
        M_Htrans[2] = 2'b11;
        S_Hresp     = 1'b1;
        S_Hready    = 1'b1;
        push("resp_isolation");
        tick();
        S_Hresp = 1'b0;
        push("isolation_done");

        // Randomised traffic, with occasional resets landing mid-transfer.
        for (int n = 0; n < 600; n++) begin
            tick();
            randomize_masters();
            Hmaster  = 2'($urandom_range(0, 3));
            S_Hready = ($urandom_range(0, 99) < 70);
            S_Hresp  = ($urandom_range(0, 99) < 15);
            S_Hrdata = $urandom;
            Hresetn  = ($urandom_range(0, 99) >= 2);
            push("random");
        end

        tick();
        @(negedge Hclk);
        #1;
        chk("scoreboard_drained", "end", 64'(sbq.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ahb_master_mux.md
# ahb_master_mux

Master-side bus multiplexer for the multi-master AHB interconnect, directly downstream of the round-robin arbiter. It routes the address/control and write-data signals of the master selected by the arbiter's `Hmaster` onto the shared bus, and tracks the data-phase owner one transfer behind the address-phase owner. It returns read data, `Hready` and `Hresp` to the masters. It also enforces handover and two-cycle-ERROR cancellation rules. The shared `Htrans`/`Hburst` it drives feed back into the arbiter.

## Interface

**Parameters**
- `NUM_MASTERS`, default `` `NUM_MASTERS `` (from parameters.svh): number of masters, ≥1.
- `ADDR_WIDTH`, default 32: address width.
- `DATA_WIDTH`, default 32: data width.
- `MASTER_WIDTH`, default `(NUM_MASTERS>1) ? $clog2(NUM_MASTERS) : 1`: owner index width.

**Ports**
- One clock; reset is synchronous and active-low.
  - `Hclk` in 1: clock.
  - `Hresetn` in 1: synchronous active-low reset.
- `Hmaster` in MASTER_WIDTH: address-phase owner from arbiter.
- `M_Haddr` in [NUM_MASTERS][ADDR_WIDTH]: per-master address.
- `M_Htrans` in [NUM_MASTERS][2]: per-master transfer type.
- `M_Hwrite` in [NUM_MASTERS]: per-master write.
- `M_Hsize` in [NUM_MASTERS][3]: per-master size.
- `M_Hburst` in [NUM_MASTERS][3]: per-master burst.
- `M_Hwdata` in [NUM_MASTERS][DATA_WIDTH]: per-master write data.
- `Haddr` out ADDR_WIDTH: shared bus address.
- `Htrans` out 2: shared bus transfer type (also to arbiter).
- `Hwrite` out 1: shared bus write.
- `Hsize` out 3: shared bus size.
- `Hburst` out 3: shared bus burst (also to arbiter).
- `Hwdata` out DATA_WIDTH: write data of the data-phase owner.
- `S_Hrdata` in DATA_WIDTH: read data from slave mux.
- `S_Hready` in 1: global ready from slave mux.
- `S_Hresp` in 1: response from slave mux (0 OKAY, 1 ERROR).
- `M_Hrdata` out DATA_WIDTH: broadcast read data.
- `M_Hready` out [NUM_MASTERS]: per-master ready.
- `M_Hresp` out [NUM_MASTERS]: per-master response.
- `Hmaster_data` out MASTER_WIDTH: data-phase owner.
- `Hproto_err` out 1: one-cycle pulse on an illegal handover.

## Operation

**Address path (combinational on `Hmaster`)**
- `Haddr`, `Hwrite`, `Hsize`, `Hburst` and raw `Htrans` are taken from master `Hmaster`.
- `Htrans` is forced to IDLE (2'b00) in either of these cases:
  - `kill` is 1;
  - the handover guard fires.
- **Handover guard:** fires when `Hmaster != prev_owner` and the new owner's `M_Htrans == SEQ` (2'b11). When it fires, `Htrans` is IDLE and `Hproto_err` = 1 for that cycle.
- `Hmaster` values ≥ NUM_MASTERS select master 0.

**Data path**
- `data_owner` register is loaded with `Hmaster` when `S_Hready` = 1.
- `Hwdata` = `M_Hwdata[data_owner]`.
- `Hmaster_data` = `data_owner`.
- `M_Hrdata` = `S_Hrdata` to all masters.
- `M_Hready[i]` = `S_Hready` for all i, so non-owners also stall their address phase.
- `M_Hresp[i]` = `S_Hresp` only when `i == data_owner`, else 0.

**Error FSM (states OKAY, ERR1, ERR2)**
- OKAY → ERR1 when `S_Hresp` = 1 and `S_Hready` = 0.
- ERR1 → ERR2 when `S_Hready` = 1.
- ERR2 → OKAY unconditionally.
- `kill` = 1 in ERR1 and ERR2. This cancels the transfer pipelined behind the errored one and the following address phase.
- `S_Hresp` = 1 while in ERR1/ERR2 does not restart the FSM.

**Registers**
- `prev_owner` <= `Hmaster` on every cycle where `S_Hready` = 1.

## Timing

**Reset (`Hresetn` = 0 sampled at a `Hclk` edge)**
- State: `data_owner` = 0, `prev_owner` = 0, FSM = OKAY.
- Outputs during and after reset follow the combinational rules with those register values. `Hproto_err` = 0 because `prev_owner` equals `Hmaster` = 0 from the arbiter in reset.
- Reset mid-transfer abandons the FSM and owners with no drain.

**Latency**
- Address path: 0 cycles.
- `Hmaster_data`: lags `Hmaster` by exactly one `S_Hready`-qualified cycle.
- Wait states (`S_Hready` = 0) hold `data_owner` and `prev_owner`.

**Simultaneous events**
- Owner change plus error: if an owner change coincides with ERR1, `kill` dominates. `Htrans` is IDLE, and `Hproto_err` still pulses if the guard condition holds.
- Single master (NUM_MASTERS = 1): the guard never fires; the owner is constant 0.

## Structure
- Shared package `ahb_pkg`:
  - `htrans_e` (IDLE 2'b00, BUSY 2'b01, NONSEQ 2'b10, SEQ 2'b11);
  - `hresp_e`;
  - `hburst_e`;
  - the `MASTER_WIDTH` function.
- One sub-module, `ahb_err_fsm`: three-state error-cancel FSM with input `S_Hready`/`S_Hresp` and output `kill`.
- Muxes and owner registers stay in the top level.

## Test plan
- **Reset:** hold `Hresetn` = 0 for 3 cycles with `M_Htrans[0]` = NONSEQ → after release `Hmaster_data` = 0, `Hproto_err` = 0, `Htrans` = NONSEQ, `Haddr` = `M_Haddr[0]`.
- **Pipelined ownership:** `Hmaster` 0→1 with `S_Hready` = 1, master 1 NONSEQ at 0x100 → same cycle `Haddr` = 0x100; next cycle `Hmaster_data` = 1 and `Hwdata` = `M_Hwdata[1]`.
- **Wait states:** `S_Hready` = 0 for 2 cycles during a master 1 data phase while `Hmaster` switches to 0 → `Hmaster_data` stays 1 until `S_Hready` rises.
- **Error:** `S_Hresp` = 1, `S_Hready` = 0, then `S_Hresp` = 1, `S_Hready` = 1 → `Htrans` = IDLE for 2 cycles despite master SEQ; `M_Hresp` = 1 only at the data owner; 3rd cycle passes SEQ through.
- **Illegal handover:** `Hmaster` 0→1 while `M_Htrans[1]` = SEQ → `Htrans` = IDLE and `Hproto_err` = 1 for one cycle; next cycle with `M_Htrans[1]` = NONSEQ passes through.
- **Response isolation:** 4 masters with data owner 2 and `S_Hresp` = 1 → `M_Hresp` = 4'b0100; `M_Hready` identical on all lanes.
